bcd_display_scan: RTL

- Downstream consumer of the digital-clock core.
- Takes packed-BCD hour/minute/second (8 bits each, {tens,ones}) and drives a 6-digit, time-multiplexed, common-anode 7-segment display.
- Provides a tear-free frame snapshot, an anti-ghosting guard cycle, leading-zero blanking, invalid-digit indication and blinking separator dots.
- Sits between the clock core outputs and the board display pins; all logic runs on clk_50.

---
 rtl/bcd_display_scan.sv | 97 +++++++++
 1 files changed

// File: rtl/bcd_display_scan.sv
// Six-digit multiplexed common-anode 7-segment driver for packed-BCD hh:mm:ss.
// Latches a whole frame at wrap, blanks anodes for one guard cycle per digit, blinks separator dots.
module bcd_display_scan #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int DIGIT_HZ = 6000,
  parameter int BLINK_HZ = 1,
  parameter int LZ_BLANK = 1
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic       enable,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_start
);
  localparam int DIV  = CLK_HZ / DIGIT_HZ;
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt_q;
  logic [2:0]    digit_q;
  logic [BW-1:0] blink_q;
  logic          phase_q;
  logic [23:0]   snap_q;

  logic          tick, wrap, blank;
  logic [3:0]    nib;
  logic [6:0]    seg_d;
  logic [5:0]    an_d;
  logic          dp_d, fs_d;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    tick = (cnt_q == CW'(DIV - 1));
    wrap = (blink_q == BW'(HALF - 1));
    case (digit_q)
      3'd1:    nib = snap_q[7:4];
      3'd2:    nib = snap_q[11:8];
      3'd3:    nib = snap_q[15:12];
      3'd4:    nib = snap_q[19:16];
      3'd5:    nib = snap_q[23:20];
      default: nib = snap_q[3:0];
    endcase
    blank = (LZ_BLANK != 0) && (digit_q == 3'd5) && (nib == 4'd0);
    seg_d = blank ? 7'b1111111 : seg7(nib);
    // a tick means the next cycle belongs to a new digit, so it becomes the guard cycle
    an_d  = (tick || blank || !enable) ? 6'b111111 : ~(6'b1 << digit_q);
    dp_d  = !(!tick && phase_q && (digit_q == 3'd2 || digit_q == 3'd4));
    fs_d  = tick && (digit_q == 3'd5);
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      digit_q     <= '0;
      blink_q     <= '0;
      phase_q     <= 1'b0;
      snap_q      <= '0;
      an          <= 6'b111111;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt_q   <= tick ? '0 : cnt_q + 1'b1;
      blink_q <= wrap ? '0 : blink_q + 1'b1;
      phase_q <= phase_q ^ wrap;
      if (tick) begin
        digit_q <= (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
        if (digit_q == 3'd5) snap_q <= {hour, minute, second};
      end
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
      frame_start <= fs_d;
    end
  end
endmodule
